alu_checker: RTL and testbench
==============================

# alu_checker

Hardware result checker sitting on the consumer side of the 4-op ALU interface (add/and/or/xor selected by a 2-bit `sel`). Each valid beat carries operands, selector and the ALU's result. The checker recomputes the expected value and counts passes and failures. It captures the first mismatching beat and raises a sticky error, replacing `$display` inspection with a self-checking monitor that works both on silicon and in simulation.

## Interface
- `WIDTH`, 4, operand/result width in bits
- `CNT_W`, 8, width of pass/fail counters
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  clear counters/capture, arm the checker (pulse)
- `stop`  in  1  end checking session (pulse)
- `in_valid`  in  1  beat on `in_a/in_b/in_sel/in_result` is valid this cycle
- `in_a`  in  WIDTH  operand a
- `in_b`  in  WIDTH  operand b
- `in_sel`  in  2  00 add, 01 and, 10 or, 11 xor
- `in_result`  in  WIDTH  ALU result under check
- `busy`  out  1  state is ARMED or DRAIN
- `pass_cnt`  out  CNT_W  matching beats since last start
- `fail_cnt`  out  CNT_W  mismatching beats since last start
- `err`  out  1  sticky: at least one mismatch since last start
- `ff_valid`  out  1  first-failure capture registers are populated
- `ff_a`, `ff_b`  out  WIDTH each  operands of first failing beat
- `ff_sel`  out  2  selector of first failing beat
- `ff_result`, `ff_expected`  out  WIDTH each  observed and expected value of first failing beat

## Operation
- Reset: state IDLE. All outputs 0: counters, `err`, `ff_*`, `busy`. Stage-1 valid cleared.
- States: IDLE, ARMED, DRAIN.
  - IDLE: `start` -> ARMED. The same edge clears counters, `err` and `ff_*`. `stop` alone is ignored.
  - ARMED: `stop` -> DRAIN. `start` (with or without `stop`) restarts: clears counters/err/ff_*, kills the in-flight stage-1 beat, stays ARMED.
  - DRAIN: unconditional -> IDLE after one cycle; completes the stage-1 beat. `start` in DRAIN is ignored.
- Beats accepted only when state is ARMED and `start`=0. `in_valid` is ignored in IDLE and DRAIN, and on a `stop` edge (the stop cycle is not sampled).
- Expected value computation:
  - add: (a+b) mod 2^WIDTH, carry discarded. 9+3=12; 15+1=0.
  - and/or/xor: bitwise.
- Compare: exact equality of `in_result` vs expected across all WIDTH bits.
- Counters saturate at 2^CNT_W-1; no wrap. Each saturates independently.
- First failure: `ff_*` loaded only when `ff_valid`=0; later failures update `fail_cnt` only. `ff_valid`, once set, holds until next `start` or `rst`.
- `err` rises with the first fail count update and is held until `start`/`rst`.
- Counters and capture remain readable (held) in IDLE after a session.

## Timing
- 2-stage pipeline.
  - Edge N (beat accepted): inputs and expected value registered into stage 1.
  - Edge N+1: compare; `pass_cnt`/`fail_cnt`/`err`/`ff_*` update.
  - Outputs reflect the beat from cycle N+1 onward (latency 2 edges from the sampling edge).
- Back-to-back beats every cycle supported; throughput 1 beat/clk.
- `busy` goes 1 the cycle after the `start` edge. It stays 1 for exactly one cycle after the `stop` edge (DRAIN), then 0.
- Beat accepted on the edge before `stop` is counted (via DRAIN).
- `rst` mid-session: next edge returns everything to reset values; in-flight beat discarded.
- `start` on edge N+1 of a pending beat: that beat is not counted; counters read 0 afterwards.

## Test plan
- Directed pass set:
  - stimulus: `start`, then beats (3,5,00,8), (9,3,00,12), (C,A,01,8), (C,A,10,E), (C,A,11,6) back-to-back, then `stop`
  - response: `pass_cnt`=5, `fail_cnt`=0, `err`=0, `ff_valid`=0; `busy` falls 1 cycle after the stop edge.
- Mismatch capture:
  - stimulus: beats (3,5,00,7) then (C,A,11,0)
  - response: `fail_cnt`=2, `err`=1, `ff_*`=(3,5,00,7,expected 8) — the second failure does not overwrite.
- Add wrap: beat (F,1,00,0) -> pass; beat (F,1,00,10000b truncated=0) counted once, result 0 passes; (F,1,00,1) -> fail, expected 0.
- Gating:
  - `in_valid` with bad data in IDLE, in DRAIN, and on the `stop` cycle -> no counter change.
  - `start`+`stop` together from IDLE -> ARMED.
- Saturation: with CNT_W=3, 10 passing beats -> `pass_cnt`=7.
- Restart/reset:
  - `start` one cycle after a failing beat is accepted -> `fail_cnt`=0, `err`=0.
  - `rst` mid-stream -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/alu_checker_if.sv
// Consumer-side view of the 4-op ALU stream plus the checker's status readback.
// The master drives beats and session control; the slave (the checker) reports results.
interface alu_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_result;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err;
    logic             ff_valid;
    logic [WIDTH-1:0] ff_a;
    logic [WIDTH-1:0] ff_b;
    logic [1:0]       ff_sel;
    logic [WIDTH-1:0] ff_result;
    logic [WIDTH-1:0] ff_expected;

    modport master (
        output start, stop, in_valid, in_a, in_b, in_sel, in_result,
        input  busy, pass_cnt, fail_cnt, err, ff_valid, ff_a, ff_b, ff_sel, ff_result,
               ff_expected
    );

    modport slave (
        input  start, stop, in_valid, in_a, in_b, in_sel, in_result,
        output busy, pass_cnt, fail_cnt, err, ff_valid, ff_a, ff_b, ff_sel, ff_result,
               ff_expected
    );
endinterface

// File: rtl/alu_checker.sv
// Self-checking monitor for an add/and/or/xor ALU: recomputes each beat, counts
// passes/fails with saturation and captures the first failing beat.
module alu_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    alu_checker_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StDrain} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e state_q, state_d;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_result_q, s1_exp_q;
    logic [1:0]       s1_sel_q;

    logic [CNT_W-1:0] pass_q, fail_q;
    logic             err_q, ff_valid_q;
    logic [WIDTH-1:0] ff_a_q, ff_b_q, ff_result_q, ff_exp_q;
    logic [1:0]       ff_sel_q;

    logic             accept;
    logic             clear;
    logic [WIDTH-1:0] expected;

    // The stop cycle itself is not sampled, and start always wins over a beat.
    assign accept = (state_q == StArmed) && !bus.start && !bus.stop && bus.in_valid;
    assign clear  = bus.start && (state_q != StDrain);

    always_comb begin
        expected = '0;
        unique case (bus.in_sel)
            2'b00: expected = bus.in_a + bus.in_b;
            2'b01: expected = bus.in_a & bus.in_b;
            2'b10: expected = bus.in_a | bus.in_b;
            2'b11: expected = bus.in_a ^ bus.in_b;
            default: expected = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StArmed;
            StArmed: begin
                if (bus.start)     state_d = StArmed;
                else if (bus.stop) state_d = StDrain;
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sel_q    <= '0;
            s1_result_q <= '0;
            s1_exp_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q      <= bus.in_a;
                s1_b_q      <= bus.in_b;
                s1_sel_q    <= bus.in_sel;
                s1_result_q <= bus.in_result;
                s1_exp_q    <= expected;
            end
        end
    end

    // A clear on the compare edge discards the stage-1 beat.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pass_q      <= '0;
            fail_q      <= '0;
            err_q       <= 1'b0;
            ff_valid_q  <= 1'b0;
            ff_a_q      <= '0;
            ff_b_q      <= '0;
            ff_sel_q    <= '0;
            ff_result_q <= '0;
            ff_exp_q    <= '0;
        end else if (s1_valid_q) begin
            if (s1_result_q == s1_exp_q) begin
                if (pass_q != CntMax) pass_q <= pass_q + CNT_W'(1);
            end else begin
                if (fail_q != CntMax) fail_q <= fail_q + CNT_W'(1);
                err_q <= 1'b1;
                if (!ff_valid_q) begin
                    ff_valid_q  <= 1'b1;
                    ff_a_q      <= s1_a_q;
                    ff_b_q      <= s1_b_q;
                    ff_sel_q    <= s1_sel_q;
                    ff_result_q <= s1_result_q;
                    ff_exp_q    <= s1_exp_q;
                end
            end
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.pass_cnt    = pass_q;
    assign bus.fail_cnt    = fail_q;
    assign bus.err         = err_q;
    assign bus.ff_valid    = ff_valid_q;
    assign bus.ff_a        = ff_a_q;
    assign bus.ff_b        = ff_b_q;
    assign bus.ff_sel      = ff_sel_q;
    assign bus.ff_result   = ff_result_q;
    assign bus.ff_expected = ff_exp_q;
endmodule

// File: tb/tb_alu_checker.sv
// Scoreboard bench for alu_checker: beats queue their expected outcome when driven
// and are retired into a reference count when the DUT's compare edge has passed.
module tb_alu_checker;
    localparam int unsigned W     = 4;
    localparam int unsigned CW    = 3;
    localparam int          CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alu_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] a, b, res, exp;
        logic [1:0] sel;
        int         due;
    } beat_t;

    beat_t sb_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    // Reference state: 0 idle, 1 armed, 2 drain.
    int         m_st;
    int         mp, mf;
    logic       merr, mffv;
    logic [3:0] mff_a, mff_b, mff_res, mff_exp;
    logic [1:0] mff_sel;

    task automatic model_clear();
        sb_q.delete();
        mp = 0; mf = 0; merr = 1'b0; mffv = 1'b0;
        mff_a = '0; mff_b = '0; mff_sel = '0; mff_res = '0; mff_exp = '0;
    endtask

    task automatic tick();
        bit    acc, clr;
        beat_t e;
        logic [4:0] sum;
        acc = (m_st == 1) && !bus.start && !bus.stop && bus.in_valid && !rst;
        clr = bus.start && (m_st != 2);
        if (acc) begin
            e.a = bus.in_a; e.b = bus.in_b; e.sel = bus.in_sel; e.res = bus.in_result;
            sum = {1'b0, e.a} + {1'b0, e.b};
            case (e.sel)
                2'b00:   e.exp = sum[3:0];
                2'b01:   e.exp = e.a & e.b;
                2'b10:   e.exp = e.a | e.b;
                default: e.exp = e.a ^ e.b;
            endcase
            e.due = cyc + 2;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_clear();
            m_st = 0;
        end else begin
            if (clr) model_clear();
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                if (e.res === e.exp) begin
                    if (mp < CMAX) mp++;
                end else begin
                    if (mf < CMAX) mf++;
                    merr = 1'b1;
                    if (!mffv) begin
                        mffv = 1'b1;
                        mff_a = e.a; mff_b = e.b; mff_sel = e.sel;
                        mff_res = e.res; mff_exp = e.exp;
                    end
                end
            end
            case (m_st)
                0:       if (bus.start) m_st = 1;
                1:       if (bus.start) m_st = 1; else if (bus.stop) m_st = 2;
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                        input logic [3:0] res);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sel = sel; bus.in_result = res;
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        bus.in_valid = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid} !== '0) begin
            errors++;
            $display("FAIL reset_status got busy=%b pass=%0d fail=%0d err=%b ffv=%b want all 0",
                     bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid);
        end
        checks++;
        if ({bus.ff_a, bus.ff_b, bus.ff_sel, bus.ff_result, bus.ff_expected} !== '0) begin
            errors++;
            $display("FAIL reset_ff got %h %h %h %h %h want 0", bus.ff_a, bus.ff_b, bus.ff_sel,
                     bus.ff_result, bus.ff_expected);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_set();
        logic [15:0] tbl [5];
        tbl = '{16'h3508, 16'h930C, 16'hCA18, 16'hCA2E, 16'hCA36};
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pass_busy_start got %b want 1", bus.busy);
        end
        for (int i = 0; i < 5; i++) beat(tbl[i][15:12], tbl[i][11:8], tbl[i][5:4], tbl[i][3:0]);
        bus.in_valid = 1'b0;
        pulse_stop();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pass_busy_drain got %b want 1", bus.busy);
        end
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_busy_idle got %b want 0", bus.busy);
        end
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid} !== {3'(mp), 3'(mf), 2'b00}
            || mp != 5) begin
            errors++;
            $display("FAIL pass_set got pass=%0d fail=%0d err=%b ffv=%b want pass=5 fail=0 0 0",
                     bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid);
        end
    endtask

    task automatic test_mismatch();
        pulse_start();
        beat(4'h3, 4'h5, 2'b00, 4'h7);
        beat(4'hC, 4'hA, 2'b11, 4'h0);
        idle(2);
        checks++;
        if ({bus.fail_cnt, bus.err, bus.ff_valid} !== {3'(mf), merr, mffv} || mf != 2) begin
            errors++;
            $display("FAIL mismatch_cnt got fail=%0d err=%b ffv=%b want fail=2 err=1 ffv=1",
                     bus.fail_cnt, bus.err, bus.ff_valid);
        end
        checks++;
        if ({bus.ff_a, bus.ff_b, bus.ff_sel, bus.ff_result, bus.ff_expected}
            !== {mff_a, mff_b, mff_sel, mff_res, mff_exp} || bus.ff_expected !== 4'h8) begin
            errors++;
            $display("FAIL mismatch_ff got %h %h %h %h %h want %h %h %h %h %h", bus.ff_a,
                     bus.ff_b, bus.ff_sel, bus.ff_result, bus.ff_expected, mff_a, mff_b,
                     mff_sel, mff_res, mff_exp);
        end
    endtask

    task automatic test_add_wrap();
        pulse_start();
        beat(4'h9, 4'h3, 2'b00, 4'hC);
        beat(4'hF, 4'h1, 2'b00, 4'h0);
        beat(4'hF, 4'h1, 2'b00, 4'h1);
        idle(2);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt} !== {3'(mp), 3'(mf)} || mp != 2 || mf != 1) begin
            errors++;
            $display("FAIL add_wrap_cnt got pass=%0d fail=%0d want pass=2 fail=1",
                     bus.pass_cnt, bus.fail_cnt);
        end
        checks++;
        if (bus.ff_expected !== 4'h0 || bus.ff_result !== 4'h1) begin
            errors++;
            $display("FAIL add_wrap_ff got res=%h exp=%h want res=1 exp=0", bus.ff_result,
                     bus.ff_expected);
        end
    endtask

    task automatic test_gating();
        int p0, f0;
        // Session is idle here; bad data must be ignored.
        beat(4'h1, 4'h1, 2'b00, 4'hF);
        beat(4'h2, 4'h2, 2'b01, 4'hF);
        idle(2);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt} !== {3'(mp), 3'(mf)}) begin
            errors++;
            $display("FAIL gate_idle got pass=%0d fail=%0d want %0d %0d", bus.pass_cnt,
                     bus.fail_cnt, mp, mf);
        end
        pulse_start();
        beat(4'h1, 4'h2, 2'b00, 4'h3);
        bus.in_result = 4'hE;
        pulse_stop();
        bus.start = 1'b1;
        beat(4'h4, 4'h4, 2'b10, 4'h0);
        bus.start = 1'b0;
        idle(2);
        checks++;
        if ({bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err} !== {1'b0, 3'(mp), 3'(mf), merr}
            || mp != 1 || mf != 0) begin
            errors++;
            $display("FAIL gate_stop_drain got busy=%b pass=%0d fail=%0d err=%b want 0 1 0 0",
                     bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err);
        end
        p0 = mp; f0 = mf;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        idle(1);
        checks++;
        if (bus.busy !== 1'b1 || bus.pass_cnt !== 3'(mp) || p0 != 1) begin
            errors++;
            $display("FAIL gate_start_stop got busy=%b pass=%0d want busy=1 pass=%0d",
                     bus.busy, bus.pass_cnt, mp);
        end
        beat(4'h6, 4'h3, 2'b11, 4'h5);
        idle(2);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt} !== {3'(mp), 3'(mf)} || mp != 1 || f0 != 0) begin
            errors++;
            $display("FAIL gate_armed_beat got pass=%0d fail=%0d want 1 0", bus.pass_cnt,
                     bus.fail_cnt);
        end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 10; i++) beat(4'h1, 4'h2, 2'b00, 4'h3);
        idle(2);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt} !== {3'(mp), 3'(mf)} || bus.pass_cnt !== 3'd7) begin
            errors++;
            $display("FAIL saturation got pass=%0d fail=%0d want 7 0", bus.pass_cnt,
                     bus.fail_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b, r;
        logic [1:0] s;
        logic [4:0] sum;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom); b = 4'($urandom); s = 2'($urandom);
            sum = {1'b0, a} + {1'b0, b};
            r = (s == 2'b00) ? sum[3:0] : (s == 2'b01) ? (a & b) : (s == 2'b10) ? (a | b) : (a ^ b);
            if (i == 2 || i == 4) r = r ^ 4'($urandom_range(1, 15));
            beat(a, b, s, r);
        end
        idle(2);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt, bus.err} !== {3'(mp), 3'(mf), merr} || mf != 2) begin
            errors++;
            $display("FAIL back_to_back got pass=%0d fail=%0d err=%b want %0d %0d %b",
                     bus.pass_cnt, bus.fail_cnt, bus.err, mp, mf, merr);
        end
        checks++;
        if ({bus.ff_a, bus.ff_b, bus.ff_sel, bus.ff_result, bus.ff_expected}
            !== {mff_a, mff_b, mff_sel, mff_res, mff_exp}) begin
            errors++;
            $display("FAIL back_to_back_ff got %h %h %h %h %h want %h %h %h %h %h", bus.ff_a,
                     bus.ff_b, bus.ff_sel, bus.ff_result, bus.ff_expected, mff_a, mff_b,
                     mff_sel, mff_res, mff_exp);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        beat(4'h3, 4'h5, 2'b00, 4'h7);
        pulse_start();
        idle(2);
        checks++;
        if ({bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid}
            !== {1'b1, 3'(mp), 3'(mf), merr, mffv} || mf != 0) begin
            errors++;
            $display("FAIL restart got busy=%b pass=%0d fail=%0d err=%b ffv=%b want 1 0 0 0 0",
                     bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid);
        end
    endtask

    task automatic test_rst_mid();
        beat(4'h3, 4'h5, 2'b00, 4'h7);
        beat(4'h1, 4'h1, 2'b00, 4'h2);
        beat(4'h2, 4'h2, 2'b00, 4'h1);
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid} !== '0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b pass=%0d fail=%0d err=%b ffv=%b want all 0",
                     bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid);
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if ({bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err, bus.ff_valid}
            !== {m_st != 0, 3'(mp), 3'(mf), merr, mffv} || m_st != 0) begin
            errors++;
            $display("FAIL rst_mid_after got busy=%b pass=%0d fail=%0d err=%b want all 0",
                     bus.busy, bus.pass_cnt, bus.fail_cnt, bus.err);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_sel = '0; bus.in_result = '0;
        m_st = 0;
        model_clear();
        tick();
        test_reset();
        test_pass_set();
        test_mismatch();
        test_add_wrap();
        pulse_stop();
        idle(1);
        test_gating();
        test_saturation();
        test_back_to_back();
        test_restart();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
